// File: rtl/image_pixel_feeder.sv
// Image pixel feeder: streams IMG_NUM images from a sync-read pixel memory to the sorter, prefetching across busy.
// Optional FEEDER_CHECKSUM_EN adds a per-image R+G+B checksum (chk_sum, chk_valid).
module image_pixel_feeder #(
    parameter int IMG_NUM     = 32,
    parameter int PIX_PER_IMG = 16384,
    localparam int IMG_W      = $clog2(IMG_NUM),
    localparam int PIX_W      = $clog2(PIX_PER_IMG),
    localparam int ADDR_W     = IMG_W + PIX_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              busy,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_data,
    output logic              ise_reset,
    output logic [23:0]       pixel_in,
    output logic [IMG_W-1:0]  image_in_index,
    output logic              done,
    output logic              err
`ifdef FEEDER_CHECKSUM_EN
    ,
    output logic [31:0]       chk_sum,
    output logic              chk_valid
`endif
);

    typedef enum logic [2:0] {HOLD, PRIME, STREAM, NEXT, LOAD, DONE} state_t;

    state_t             state_q, state_d;
    logic [PIX_W-1:0]   pix_q, pix_d;
    logic [IMG_W-1:0]   img_q, img_d;
    logic [IMG_W-1:0]   idx_q, idx_d;
    logic [23:0]        pixel_q, pixel_d;
    logic               ise_reset_q, ise_reset_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rd;
    logic [ADDR_W-1:0]  addr;

    logic [PIX_W:0]     pix_p2;
    logic               advance;
    logic               last_pix;
    logic               last_img;

    assign pix_p2   = {1'b0, pix_q} + (PIX_W+1)'(2);
    assign advance  = (state_q == STREAM) && !busy;
    assign last_pix = (pix_q == PIX_W'(PIX_PER_IMG - 1));
    assign last_img = (img_q == IMG_W'(IMG_NUM - 1));

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        img_d       = img_q;
        idx_d       = idx_q;
        pixel_d     = pixel_q;
        ise_reset_d = ise_reset_q;
        done_d      = done_q;
        err_d       = err_q;
        rd          = 1'b0;
        addr        = '0;
        case (state_q)
            HOLD: begin
                ise_reset_d = 1'b1;
                rd          = 1'b1;
                addr        = {img_q, PIX_W'(0)};
                state_d     = PRIME;
            end
            PRIME: begin
                pixel_d     = mem_data;
                rd          = 1'b1;
                addr        = {img_q, PIX_W'(1)};
                ise_reset_d = 1'b0;
                state_d     = STREAM;
            end
            STREAM: begin
                if (advance) begin
                    pixel_d = mem_data;
                    // Prefetch two ahead: mem_data already holds pix+1 for the next sample.
                    if (pix_p2 < (PIX_W+1)'(PIX_PER_IMG)) begin
                        rd   = 1'b1;
                        addr = {img_q, pix_p2[PIX_W-1:0]};
                    end
                    if (last_pix) begin
                        if (last_img) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            img_d   = img_q + IMG_W'(1);
                            state_d = NEXT;
                        end
                    end else begin
                        pix_d = pix_q + PIX_W'(1);
                    end
                end
            end
            NEXT: begin
                idx_d   = img_q;
                rd      = 1'b1;
                addr    = {img_q, PIX_W'(0)};
                err_d   = err_q | !busy;
                state_d = LOAD;
            end
            LOAD: begin
                pixel_d = mem_data;
                rd      = 1'b1;
                addr    = {img_q, PIX_W'(1)};
                pix_d   = '0;
                err_d   = err_q | !busy;
                state_d = STREAM;
            end
            default: begin
                state_d = DONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= HOLD;
            pix_q       <= '0;
            img_q       <= '0;
            idx_q       <= '0;
            pixel_q     <= '0;
            ise_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            img_q       <= img_d;
            idx_q       <= idx_d;
            pixel_q     <= pixel_d;
            ise_reset_q <= ise_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // HOLD issues its read combinationally, so gate the strobe while reset is asserted.
    assign mem_rd         = rd & reset_n;
    assign mem_addr       = reset_n ? addr : '0;
    assign ise_reset      = ise_reset_q;
    assign pixel_in       = pixel_q;
    assign image_in_index = idx_q;
    assign done           = done_q;
    assign err            = err_q;

`ifdef FEEDER_CHECKSUM_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] chk_sum_q, chk_sum_d;
    logic        chk_valid_q, chk_valid_d;
    logic [31:0] rgb;

    assign rgb = 32'(pixel_q[23:16]) + 32'(pixel_q[15:8]) + 32'(pixel_q[7:0]);

    always_comb begin
        acc_d       = acc_q;
        chk_sum_d   = chk_sum_q;
        chk_valid_d = 1'b0;
        if (advance) begin
            if (last_pix) begin
                chk_sum_d   = acc_q + rgb;
                chk_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = acc_q + rgb;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            chk_sum_q   <= '0;
            chk_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            chk_sum_q   <= chk_sum_d;
            chk_valid_q <= chk_valid_d;
        end
    end

    assign chk_sum   = chk_sum_q;
    assign chk_valid = chk_valid_q;
`endif

endmodule

// File: tb/tb_image_pixel_feeder.sv
// Bench for image_pixel_feeder: a sorter model drives busy and compares the sampled stream with the memory image.
module tb_image_pixel_feeder;
    localparam int IMG_NUM = 4;
    localparam int PIX     = 16;
    localparam int IMG_W   = 2;
    localparam int ADDR_W  = 6;
    localparam int DEPTH   = IMG_NUM * PIX;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              busy = 1'b0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [23:0]       mem_data = '0;
    logic              ise_reset;
    logic [23:0]       pixel_in;
    logic [IMG_W-1:0]  image_in_index;
    logic              done;
    logic              err;
`ifdef FEEDER_CHECKSUM_EN
    logic [31:0]       chk_sum;
    logic              chk_valid;
`endif

    logic [23:0] mem [DEPTH];
    int          n_vec = 0;
    int          n_bad = 0;
    bit          err_exp = 1'b0;

    image_pixel_feeder #(.IMG_NUM(IMG_NUM), .PIX_PER_IMG(PIX)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .busy           (busy),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .ise_reset      (ise_reset),
        .pixel_in       (pixel_in),
        .image_in_index (image_in_index),
        .done           (done),
        .err            (err)
`ifdef FEEDER_CHECKSUM_EN
        ,
        .chk_sum        (chk_sum),
        .chk_valid      (chk_valid)
`endif
    );

    always #5 clk = ~clk;

    // Sync-read memory: data appears the cycle after a strobe and holds otherwise.
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        check("rst_ise_reset", ise_reset, 1);
        check("rst_pixel_in", pixel_in, 0);
        check("rst_index", image_in_index, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
`ifdef FEEDER_CHECKSUM_EN
        check("rst_chk_sum", chk_sum, 0);
        check("rst_chk_valid", chk_valid, 0);
`endif
    endtask

    task automatic release_reset();
        int cnt;
        cnt = 0;
        reset_n = 1'b1;
        while (ise_reset && cnt < 10) begin
            step();
            cnt++;
        end
        check("ise_reset_fall_cycles", cnt, 2);
    endtask

    // Sorter model: samples pixel_in on every busy-low cycle, then holds busy across the image gap.
    task automatic run(input int abort_img, input int short_img);
        for (int img = 0; img < IMG_NUM; img++) begin
            int sum;
            sum = 0;
            for (int k = 0; k < PIX; k++) begin
                if (img == abort_img && k == 5) return;
                if (k > 0 && $urandom_range(7) == 0) begin
                    int n;
                    n = $urandom_range(3, 1);
                    busy = 1'b1;
                    for (int s = 0; s < n; s++) step();
                    busy = 1'b0;
                end
                check("pixel", pixel_in, mem[img*PIX + k]);
                check("index", image_in_index, img);
                sum += int'(mem[img*PIX + k][23:16]) + int'(mem[img*PIX + k][15:8])
                     + int'(mem[img*PIX + k][7:0]);
                step();
            end
`ifdef FEEDER_CHECKSUM_EN
            check("chk_valid", chk_valid, 1);
            check("chk_sum", chk_sum, sum);
`endif
            if (img == IMG_NUM - 1) begin
                check("done_set", done, 1);
                for (int s = 0; s < 4; s++) begin
                    step();
                    check("done_mem_rd", mem_rd, 0);
                    check("done_sticky", done, 1);
                end
            end else begin
                check("done_early", done, 0);
                busy = 1'b1;
                if (img == short_img) begin
                    step();
                    busy = 1'b0;
                    err_exp = 1'b1;
                    step();
                    busy = 1'b1;
                    step();
                    step();
                end else begin
                    int h;
                    h = $urandom_range(6, 4);
                    for (int s = 0; s < h; s++) step();
                end
                busy = 1'b0;
                check("err", err, err_exp);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 24'($urandom());
        reset_n = 1'b0;
        busy    = 1'b0;
        step();
        step();
        check_reset();
        release_reset();
        run(2, 1);

        reset_n = 1'b0;
        #1;
        err_exp = 1'b0;
        check_reset();
        step();
        check_reset();
        release_reset();
        run(-1, -1);
        check("err_final", err, 0);

`ifdef FEEDER_CHECKSUM_EN
        reset_n = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 24'h010203;
        step();
        release_reset();
        run(-1, -1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
